// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared types and constants for the program-image loader.
//   state_e         loader state encoding
//   WORD_BYTES      byte stride between consecutive instruction words
//   HDR_*_IDX       position of each header field in the host word stream
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_COUNT,
    ST_LOAD,
    ST_CHECK,
    ST_START,
    ST_RUN,
    ST_ERROR
  } state_e;

  localparam int unsigned WORD_BYTES    = 4;
  localparam int unsigned HDR_ADDR_IDX  = 0;
  localparam int unsigned HDR_COUNT_IDX = 1;

  // State that receives the header field at stream position idx.
  function automatic state_e hdr_state(input int unsigned idx);
    return (idx == HDR_ADDR_IDX) ? ST_GET_ADDR : ST_GET_COUNT;
  endfunction

endpackage

// File: rtl/boot_loader_hold_timer.sv
// loader_hold_timer: down-counter that times how long the CPU stays parked
// once the image is in memory.
//   clk, reset  clock and synchronous active-high reset
//   load_i      reload the counter with HOLD_CYCLES
//   en_i        count one cycle down (saturates at zero)
//   expired_o   registered flag, set once HOLD_CYCLES enabled cycles have elapsed
module loader_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             expired_q;

  // Expiry is registered alongside the count so it rises in the same cycle
  // the count reaches zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else if (load_i) begin
      cnt_q     <= CNT_W'(HOLD_CYCLES);
      expired_q <= (HOLD_CYCLES == 0);
    end else if (en_i) begin
      if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
      expired_q <= (cnt_q <= CNT_W'(1));
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a program image (base address, word count, payload)
// over a valid/ready stream, writes it into instruction memory and then
// releases the CPU from the start vector.
//   clk, reset                  clock, synchronous active-high reset
//   s_valid/s_ready/s_data      host word stream
//   imem_we/imem_addr/imem_wdata  instruction-memory write port
//   pcSelect/startAddress       park the CPU PC at the start vector while 1
//   busy/done/error             load in progress / released (sticky) / bad image (sticky)
// Optional: define LOADER_CHECKSUM_EN to require a trailing checksum word
// (32-bit wrapping sum of base, count and payload) before release.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MAX_WORDS   = 1024,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              pcSelect,
  output logic [31:0]       startAddress,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned REM_W = $clog2(MAX_WORDS + 1);
`ifdef LOADER_CHECKSUM_EN
  localparam state_e AFTER_IMAGE = ST_CHECK;
`else
  localparam state_e AFTER_IMAGE = ST_START;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [REM_W-1:0]  remain_q, remain_d;
  logic [31:0]       start_q, start_d;
  logic              s_ready_q, s_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pcsel_q, pcsel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif
  logic              xfer;
  logic              hold_load, hold_en, hold_expired;

  loader_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load_i    (hold_load),
    .en_i      (hold_en),
    .expired_o (hold_expired)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    start_d  = start_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    xfer     = s_valid && s_ready_q;

    case (state_q)
      ST_IDLE: state_d = hdr_state(HDR_ADDR_IDX);
      ST_GET_ADDR: if (xfer) begin
        if (s_data[1:0] != 2'b00) begin
          state_d = ST_ERROR;
        end else begin
          start_d = 32'(s_data);
          ptr_d   = ADDR_W'(s_data);
`ifdef LOADER_CHECKSUM_EN
          csum_d  = 32'(s_data);
`endif
          state_d = hdr_state(HDR_COUNT_IDX);
        end
      end
      ST_GET_COUNT: if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
        csum_d = csum_q + 32'(s_data);
`endif
        if (s_data > DATA_W'(MAX_WORDS)) begin
          state_d = ST_ERROR;
        end else if (s_data == '0) begin
          state_d = AFTER_IMAGE;
        end else begin
          remain_d = REM_W'(s_data);
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: if (xfer) begin
        we_d     = 1'b1;
        addr_d   = ptr_q;
        wdata_d  = s_data;
        ptr_d    = ptr_q + ADDR_W'(WORD_BYTES);
        remain_d = remain_q - REM_W'(1);
`ifdef LOADER_CHECKSUM_EN
        csum_d   = csum_q + 32'(s_data);
`endif
        if (remain_q == REM_W'(1)) state_d = AFTER_IMAGE;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: if (xfer) begin
        state_d = (32'(s_data) == csum_q) ? ST_START : ST_ERROR;
      end
`endif
      ST_START: if (hold_expired) state_d = ST_RUN;
      ST_RUN, ST_ERROR: state_d = state_q;
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered decodes of the state being entered.
    s_ready_d = state_d inside {ST_GET_ADDR, ST_GET_COUNT, ST_LOAD, ST_CHECK};
    busy_d    = state_d inside {ST_GET_ADDR, ST_GET_COUNT, ST_LOAD, ST_CHECK, ST_START};
    pcsel_d   = (state_d != ST_RUN);
    done_d    = (state_d == ST_RUN);
    error_d   = (state_d == ST_ERROR);

    // The first START cycle commits the final write; the hold runs after it.
    hold_load = (state_d == ST_START) && (state_q != ST_START);
    hold_en   = (state_q == ST_START);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      remain_q  <= '0;
      start_q   <= '0;
      s_ready_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pcsel_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      remain_q  <= remain_d;
      start_q   <= start_d;
      s_ready_q <= s_ready_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      pcsel_q   <= pcsel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign s_ready      = s_ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign pcSelect     = pcsel_q;
  assign startAddress = start_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed and randomized image loads against a reference
// model of the expected memory writes, release timing and status flags.
module tb_boot_loader;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned MAX_WORDS   = 1024;
  localparam int unsigned HOLD_CYCLES = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              pcSelect;
  logic [31:0]       startAddress;
  logic              busy, done, error;

  boot_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .pcSelect(pcSelect), .startAddress(startAddress),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          c;
  } wr_t;

  wr_t wr_q[$];
  int  pc_fall = -1;
  int  checks = 0;
  int  errors = 0;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and record what the DUT shows there.
  task automatic tick();
    @(negedge clk);
    if (imem_we === 1'b1) wr_q.push_back('{32'(imem_addr), 32'(imem_wdata), int'(cyc)});
    if (pcSelect === 1'b0 && pc_fall < 0) pc_fall = int'(cyc);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
    chk({tag, "_pcSelect"}, 32'(pcSelect), 32'd1);
    chk({tag, "_startAddress"}, startAddress, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = $urandom;
    tick();
    check_reset_vals("reset");
    tick();
    wr_q.delete();
    pc_fall = -1;
    reset   = 1'b0;
  endtask

  // Present one word; returns the cycle index at which it was driven.
  task automatic send_word(input logic [31:0] data, input bit gap, output int drv);
    int t = 0;
    drv = -1;
    while (s_ready !== 1'b1 && t < 50) begin
      s_valid = 1'b0;
      s_data  = $urandom;
      tick();
      t++;
    end
    if (s_ready !== 1'b1) begin
      chk("ready_timeout", 32'(s_ready), 32'd1);
    end else begin
      s_valid = 1'b1;
      s_data  = data;
      drv     = int'(cyc);
      tick();
      s_valid = 1'b0;
      s_data  = $urandom;
      if (gap) tick();
    end
  endtask

  // Send a complete image and compare against what the image rules predict.
  task automatic run_image(input string name, input logic [31:0] base, input int unsigned n,
                           input logic [31:0] words[$], input bit gap, input bit csum_bad);
    int          drv, last_drv;
    int          pay_drv[$];
    bit          hdr_bad, exp_err;
    logic [31:0] sum;
    int unsigned exp_writes;

    hdr_bad = (base % 4 != 0) || (n > MAX_WORDS);
    exp_err = hdr_bad;
`ifdef LOADER_CHECKSUM_EN
    exp_err = exp_err || csum_bad;
`endif
    exp_writes = hdr_bad ? 0 : n;
    sum = base + n;
    foreach (words[i]) sum = sum + words[i];

    do_reset();
    send_word(base, gap, drv);
    last_drv = drv;
    if (base % 4 == 0) begin
      chk({name, "_busy_hdr"}, 32'(busy), 32'd1);
      send_word(32'(n), gap, drv);
      last_drv = drv;
      if (n <= MAX_WORDS) begin
        for (int i = 0; i < int'(n); i++) begin
          send_word(words[i], gap, drv);
          pay_drv.push_back(drv);
          last_drv = drv;
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(csum_bad ? sum + 32'd1 : sum, gap, drv);
        last_drv = drv;
`endif
      end
    end
    repeat (HOLD_CYCLES + 6) tick();

    chk({name, "_error"}, 32'(error), 32'(exp_err));
    chk({name, "_done"}, 32'(done), 32'(!exp_err));
    chk({name, "_pcSelect"}, 32'(pcSelect), 32'(exp_err));
    chk({name, "_busy_end"}, 32'(busy), 32'd0);
    chk({name, "_s_ready_end"}, 32'(s_ready), 32'd0);
    if (exp_err) begin
      chk({name, "_never_released"}, 32'(pc_fall), 32'hFFFF_FFFF);
    end else begin
      chk({name, "_startAddress"}, startAddress, base);
      chk({name, "_release_cycle"}, 32'(pc_fall), 32'(last_drv + int'(HOLD_CYCLES) + 2));
    end
    chk({name, "_write_count"}, 32'(wr_q.size()), 32'(exp_writes));
    if (wr_q.size() == exp_writes) begin
      for (int i = 0; i < int'(exp_writes); i++) begin
        chk($sformatf("%s_addr%0d", name, i), wr_q[i].addr, base + 32'(4 * i));
        chk($sformatf("%s_data%0d", name, i), wr_q[i].data, words[i]);
        chk($sformatf("%s_wcyc%0d", name, i), 32'(wr_q[i].c), 32'(pay_drv[i] + 1));
      end
    end
  endtask

  initial begin
    logic [31:0] wq[$];
    logic [31:0] b;
    int          n, drv;

    // Directed: three-word image, streaming and with alternating stalls.
    wq = '{32'hAA, 32'hBB, 32'hCC};
    run_image("img3", 32'h0, 3, wq, 1'b0, 1'b0);
    run_image("img3_stall", 32'h0, 3, wq, 1'b1, 1'b0);

    // Header errors and the empty image.
    run_image("misalign", 32'h0000_0102, 3, wq, 1'b0, 1'b0);
    wq.delete();
    run_image("too_many", 32'h0, MAX_WORDS + 1, wq, 1'b0, 1'b0);
    run_image("empty", 32'h40, 0, wq, 1'b0, 1'b0);

    // Reset while the second payload word of a 4-word load is offered.
    do_reset();
    send_word(32'h200, 1'b0, drv);
    send_word(32'd4, 1'b0, drv);
    send_word(32'h1111_0000, 1'b0, drv);
    s_valid = 1'b1;
    s_data  = 32'h2222_0000;
    reset   = 1'b1;
    tick();
    check_reset_vals("midreset");
    tick();
    chk("midreset_writes", 32'(wr_q.size()), 32'd1);
    chk("midreset_no_we", 32'(imem_we), 32'd0);
    s_valid = 1'b0;
    reset   = 1'b0;
    wq = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
    run_image("after_reset", 32'h200, 4, wq, 1'b0, 1'b0);

    // Address wrap past the top of the address space, and the largest image.
    wq = '{$urandom, $urandom, $urandom, $urandom};
    run_image("wrap", 32'hFFFF_FFF8, 4, wq, 1'b0, 1'b0);
    wq.delete();
    for (int i = 0; i < int'(MAX_WORDS); i++) wq.push_back($urandom);
    run_image("max_words", 32'h1000, MAX_WORDS, wq, 1'b0, 1'b0);

    // Randomized images.
    for (int k = 0; k < 8; k++) begin
      b = $urandom;
      if ($urandom_range(0, 3) != 0) b[1:0] = 2'b00;
      n = $urandom_range(0, 8);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      run_image($sformatf("rand%0d", k), b, n, wq, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

`ifdef LOADER_CHECKSUM_EN
    wq = '{32'h5};
    run_image("csum_good", 32'h10, 1, wq, 1'b0, 1'b0);
    run_image("csum_bad", 32'h10, 1, wq, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
Synthesizable loader that writes a program image into the instruction memory and then releases the pipeline from its start vector. It receives a word stream (load address, word count, payload) over a valid/ready handshake and drives instruction-memory write strobes. It holds pcSelect/startAddress so the CPU stays parked at the start vector, then releases the CPU once loading is complete. It sits between an external host link and the pipeline's fetch unit.

Parameters:
DATA_W, 32, stream word and instruction width
ADDR_W, 32, instruction-memory byte-address width
MAX_WORDS, 1024, largest accepted word count
HOLD_CYCLES, 2, cycles pcSelect stays high after the load completes

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
s_valid  in  1  host word valid
s_ready  out  1  loader can accept word
s_data  in  DATA_W  host word
imem_we  out  1  instruction-memory write enable, one cycle per word
imem_addr  out  ADDR_W  byte address of write
imem_wdata  out  DATA_W  write data
pcSelect  out  1  1 = CPU PC forced to startAddress
startAddress  out  32  start vector given to the pipeline
busy  out  1  load in progress
done  out  1  sticky; program released
error  out  1  sticky; bad header, checked until reset

Behaviour:
- Reset values: s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, pcSelect=1, startAddress=0, busy=0, done=0, error=0, state=IDLE.
- Transfer rule: a word transfers only on a clk edge with s_valid&&s_ready. s_ready=1 only in GET_ADDR, GET_COUNT, LOAD (and CHECK).
- IDLE: one cycle after reset deasserts, go to GET_ADDR. busy=1 from GET_ADDR through START.
- GET_ADDR: latch the word as base.
  - If base[1:0]!=0, go to ERROR.
  - Otherwise startAddress<=base and go to GET_COUNT.
- GET_COUNT: latch N.
  - If N>MAX_WORDS, go to ERROR.
  - If N==0, go to START (or CHECK when the checksum feature is on).
  - Otherwise go to LOAD with ptr=base and remaining=N.
- LOAD: each transferred word produces, on the next cycle, imem_we=1, imem_addr=ptr, imem_wdata=word.
  - ptr+=4, wrapping mod 2^ADDR_W with no error.
  - The last word goes to START (or CHECK).
  - Write latency is 1 cycle from transfer; back-to-back transfers give back-to-back writes.
  - s_valid low stalls with no write.
- START: pcSelect stays 1 for exactly HOLD_CYCLES cycles, then pcSelect<=0, done<=1, busy<=0, go to RUN.
- RUN: terminal; outputs frozen, s_ready=0; only reset leaves.
- ERROR: terminal; error=1, pcSelect held 1 (CPU never released), busy=0, s_ready=0.
- pcSelect is 1 in every state except RUN.
- Reset mid-operation (any state): all outputs return to reset values next cycle. Partially written memory is not cleared; the host must resend the full image.
- s_data is ignored when s_valid=0. No transfer occurs while reset=1.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- When defined: after the payload (or directly after N==0), state CHECK accepts one more word.
  - It must equal the 32-bit wrapping sum of base, N and all payload words.
  - On a match go to START; on a mismatch go to ERROR.
  - Memory writes already issued stay in place, but the CPU is not released.
- When undefined: there is no CHECK state and LOAD/GET_COUNT go straight to START.

Decomposition:
- Package boot_loader_pkg holds:
  - the state encoding typedef (IDLE, GET_ADDR, GET_COUNT, LOAD, CHECK, START, RUN, ERROR);
  - the constant WORD_BYTES=4;
  - the header field order constants.
- One sub-module is natural: loader_hold_timer, a down-counter loaded with HOLD_CYCLES that reports expiry to the START state.
- The checksum accumulator stays inline.

Test Plan:
- Base=0x00000000, N=3, words 0xAA,0xBB,0xCC, valid every cycle -> writes (0x0,0xAA),(0x4,0xBB),(0x8,0xCC) on consecutive cycles; pcSelect=1 for 2 cycles after the last write, then 0; done=1; startAddress=0x0.
- Same image with s_valid toggled 1/0 each cycle -> same three writes in order, no duplicates, no writes on stall cycles.
- Base=0x00000102 -> error=1 after the header word; no imem_we ever; pcSelect stays 1.
- N=MAX_WORDS+1 (1025) -> error=1; N=0 with base 0x40 -> no writes, startAddress=0x40, done=1 after HOLD_CYCLES.
- Reset asserted during the second payload word of a 4-word load -> next cycle all outputs at reset values; a fresh full image then loads and releases correctly.
- LOADER_CHECKSUM_EN: base 0x10, N=1, word 0x5 -> checksum 0x16 gives done=1; checksum 0x17 gives error=1 and pcSelect held 1.
